aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of cipher rounds; legal values 10, 12, 14.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  new block (plaintext and key) presented to datapath.
REQ-005 SHALL have port in_ready  output  1  controller accepts a block this cycle.
REQ-006 SHALL have port key_valid  input  1  round key for round_idx available from key schedule.
REQ-007 SHALL have port key_req  output  1  request round key for round_idx.
REQ-008 SHALL have port round_idx  output  4  current round index, 0..NR.
REQ-009 SHALL have port st_en  output  1  datapath state register load enable.
REQ-010 SHALL have port ld_input  output  1  state mux selects plaintext XOR key0 (initial AddRoundKey).
REQ-011 SHALL have port mix_bypass  output  1  datapath skips MixColumns (final round).
REQ-012 SHALL have port out_valid  output  1  ciphertext in datapath state register is valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, ROUND, FINAL, OUT.
REQ-016 IDLE: in_ready=1; in_valid=1 -> INIT next cycle with round_idx=0; otherwise stay.
REQ-017 INIT: key_req=1, round_idx=0; key_valid=1 -> st_en=1, ld_input=1, round_idx<=1, go ROUND; key_valid=0 -> hold, st_en=0.
REQ-018 ROUND: key_req=1; key_valid=1 -> st_en=1, round_idx<=round_idx+1, go FINAL when round_idx==NR-1, else stay; key_valid=0 -> stall, no outputs change.
REQ-019 FINAL: key_req=1, mix_bypass=1, round_idx=NR; key_valid=1 -> st_en=1, go OUT.
REQ-020 OUT: out_valid=1, held until out_ready=1, then IDLE; round_idx holds NR.
REQ-021 st_en, ld_input, mix_bypass SHALL be combinational from state and key_valid; ld_input and mix_bypass never high together.
REQ-022 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE ignored; no back-to-back accept from OUT (new block accepted earliest the cycle after OUT exits).
REQ-023 Latency with key_valid tied high: accept at cycle 0, out_valid first high at cycle NR+2 (12 for NR=10); st_en asserted exactly NR+1 times per block.
REQ-024 round_idx counter SHALL never exceed NR; no wrap-around.
REQ-025 key_valid outside INIT/ROUND/FINAL SHALL be ignored.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, round_idx=0; outputs then: in_ready=1, key_req=0, st_en=0, ld_input=0, mix_bypass=0, out_valid=0, busy=0.
REQ-027 rst mid-operation (any state) SHALL abandon the block with no further st_en; rst has priority over all inputs.

Structure
REQ-028 State enum, NR legal-value constants and round_idx width constant SHALL reside in shared package aes_pkg.
REQ-029 Block SHALL be a single module with no sub-modules; datapath (shiftRows, SubBytes, MixColumns, AddRoundKey, state register) stays external.

Verification
REQ-030 key_valid=1, in_valid pulse -> in_ready drops next cycle, st_en pulses 11 times with round_idx 0..10, ld_input only on idx 0, mix_bypass only on idx 10, out_valid at cycle 12.
REQ-031 key_valid low 3 cycles during round 5 -> round_idx holds 5, st_en=0 during stall, out_valid at cycle 15.
REQ-032 out_ready held low 4 cycles in OUT -> out_valid stays 1, in_valid ignored, in_ready=0; IDLE on cycle after out_ready=1.
REQ-033 rst asserted in ROUND at round_idx=6 -> next cycle IDLE, round_idx=0, all outputs at reset values, new block completes normally.
REQ-034 NR=14 build -> out_valid at cycle 16, mix_bypass only at round_idx=14.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: FSM state encoding,
// legal round counts per key size, and the round index width.
// No logic; imported by the controller and anything that decodes its state.
package aes_pkg;

    // Controller states: wait for block, initial AddRoundKey, middle rounds,
    // last round without MixColumns, ciphertext hand-off.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_OUT   = 3'd4
    } aes_state_t;

    // Round counts for AES-128 / AES-192 / AES-256.
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    // Wide enough to hold round indices 0..14.
    localparam int ROUND_IDX_W = 4;

endpackage

// File: rtl/aes_round_ctrl.sv
// Purpose: sequences an external iterative AES datapath through NR+1 round-key loads.
// Latency: accept in cycle 0, out_valid from cycle NR+2 when key_valid stays high.
// Backpressure: key_valid low stalls the round in place; out_ready low holds out_valid.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   key_valid,
    output logic                   key_req,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   st_en,
    output logic                   ld_input,
    output logic                   mix_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    // Index of the last middle round; reaching it with a key moves us to FINAL.
    localparam logic [ROUND_IDX_W-1:0] LP_LAST_MID = ROUND_IDX_W'(NR - 1);

    aes_state_t                 r_state;
    logic [ROUND_IDX_W-1:0]     r_round_idx;
    aes_state_t                 w_state_nxt;
    logic [ROUND_IDX_W-1:0]     w_idx_nxt;

    // State and round counter registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_round_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_round_idx <= w_idx_nxt;
        end
    end

    // Next-state, counter update and datapath controls, all from state and key_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_round_idx;
        in_ready    = 1'b0;
        key_req     = 1'b0;
        st_en       = 1'b0;
        ld_input    = 1'b0;
        mix_bypass  = 1'b0;
        out_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_INIT;
                    w_idx_nxt   = '0;
                end
            end
            S_INIT: begin
                key_req = 1'b1;
                if (key_valid) begin
                    st_en       = 1'b1;
                    ld_input    = 1'b1;
                    w_idx_nxt   = ROUND_IDX_W'(1);
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                key_req = 1'b1;
                if (key_valid) begin
                    st_en     = 1'b1;
                    w_idx_nxt = r_round_idx + ROUND_IDX_W'(1);
                    if (r_round_idx == LP_LAST_MID) begin
                        w_state_nxt = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                // Counter already sits at NR here and is not advanced further.
                key_req    = 1'b1;
                mix_bypass = 1'b1;
                if (key_valid) begin
                    st_en       = 1'b1;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign round_idx = r_round_idx;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=14 instances driven by directed blocks.
// Expected st_en records and out_valid cycles are queued at issue time.
// A negedge monitor pops and compares whenever the DUT pulses st_en or raises out_valid.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, key_valid, key_req, st_en, ld_input;
    logic       mix_bypass, out_valid, out_ready, busy;
    logic [3:0] round_idx;

    logic       in_valid14, in_ready14, key_valid14, key_req14, st_en14, ld_input14;
    logic       mix_bypass14, out_valid14, out_ready14, busy14;
    logic [3:0] round_idx14;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10)) u_dut10 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .key_valid(key_valid), .key_req(key_req),
        .round_idx(round_idx), .st_en(st_en),
        .ld_input(ld_input), .mix_bypass(mix_bypass),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    aes_round_ctrl #(.NR(14)) u_dut14 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid14), .in_ready(in_ready14),
        .key_valid(key_valid14), .key_req(key_req14),
        .round_idx(round_idx14), .st_en(st_en14),
        .ld_input(ld_input14), .mix_bypass(mix_bypass14),
        .out_valid(out_valid14), .out_ready(out_ready14),
        .busy(busy14)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int idx;
        bit ld;
        bit mix;
    } st_exp_t;

    st_exp_t q_st10[$];
    st_exp_t q_st14[$];
    int      q_out10[$];
    int      q_out14[$];
    bit      ov10_q = 1'b0;
    bit      ov14_q = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every st_en pulse and every out_valid rising cycle.
    always @(negedge clk) begin : mon
        st_exp_t e;
        int      c;
        if (st_en === 1'b1) begin
            if (q_st10.size() == 0) chk("st10_unexpected", 1, 0);
            else begin
                e = q_st10.pop_front();
                chk("st10_idx", int'(round_idx), e.idx);
                chk("st10_ld", int'(ld_input), int'(e.ld));
                chk("st10_mix", int'(mix_bypass), int'(e.mix));
            end
        end
        if (out_valid === 1'b1 && !ov10_q) begin
            if (q_out10.size() == 0) chk("out10_unexpected", 1, 0);
            else begin
                c = q_out10.pop_front();
                chk("out10_cycle", cyc, c);
            end
        end
        ov10_q = (out_valid === 1'b1);

        if (st_en14 === 1'b1) begin
            if (q_st14.size() == 0) chk("st14_unexpected", 1, 0);
            else begin
                e = q_st14.pop_front();
                chk("st14_idx", int'(round_idx14), e.idx);
                chk("st14_ld", int'(ld_input14), int'(e.ld));
                chk("st14_mix", int'(mix_bypass14), int'(e.mix));
            end
        end
        if (out_valid14 === 1'b1 && !ov14_q) begin
            if (q_out14.size() == 0) chk("out14_unexpected", 1, 0);
            else begin
                c = q_out14.pop_front();
                chk("out14_cycle", cyc, c);
            end
        end
        ov14_q = (out_valid14 === 1'b1);
    end

    // Present one block for one cycle; t0 is the cycle number of the accept cycle.
    task automatic issue(input bit big, output int t0);
        @(posedge clk); #1;
        if (big) in_valid14 = 1'b1;
        else     in_valid   = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_valid14 = 1'b0;
        if (big) chk("in_ready14_drop", int'(in_ready14), 0);
        else     chk("in_ready_drop", int'(in_ready), 0);
    endtask

    // Queue st_en records for indices 0..last; optionally the out_valid cycle.
    task automatic push_blk(input bit big, input int last, input bit with_out, input int t_out);
        int      nr;
        st_exp_t e;
        nr = big ? 14 : 10;
        for (int i = 0; i <= last; i++) begin
            e.idx = i;
            e.ld  = (i == 0);
            e.mix = (i == nr);
            if (big) q_st14.push_back(e);
            else     q_st10.push_back(e);
        end
        if (with_out) begin
            if (big) q_out14.push_back(t_out);
            else     q_out10.push_back(t_out);
        end
    endtask

    task automatic wait_idle(input bit big, input string name);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (big ? in_ready14 : in_ready) return;
        end
        chk(name, 0, 1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"},   int'(in_ready), 1);
        chk({tag, "_key_req"},    int'(key_req), 0);
        chk({tag, "_st_en"},      int'(st_en), 0);
        chk({tag, "_ld_input"},   int'(ld_input), 0);
        chk({tag, "_mix_bypass"}, int'(mix_bypass), 0);
        chk({tag, "_out_valid"},  int'(out_valid), 0);
        chk({tag, "_busy"},       int'(busy), 0);
        chk({tag, "_round_idx"},  int'(round_idx), 0);
    endtask

    initial begin : stim
        int t0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        key_valid   = 1'b1;
        out_ready   = 1'b1;
        in_valid14  = 1'b0;
        key_valid14 = 1'b1;
        out_ready14 = 1'b1;

        // Reset state, with key_valid high to confirm it is ignored in IDLE.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        chk("rst_in_ready14", int'(in_ready14), 1);
        rst = 1'b0;

        // Plain block, keys always available.
        issue(1'b0, t0);
        push_blk(1'b0, 10, 1'b1, t0 + 12);
        wait_idle(1'b0, "blk1_timeout");

        // Key stall for three cycles while round 5 is pending.
        issue(1'b0, t0);
        push_blk(1'b0, 10, 1'b1, t0 + 15);
        for (int i = 0; i < 40 && round_idx != 4'd5; i++) begin
            @(posedge clk); #1;
        end
        chk("stall_reach_idx5", int'(round_idx), 5);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            key_valid = 1'b0;
            #1;
            chk("stall_idx_hold", int'(round_idx), 5);
            chk("stall_st_en", int'(st_en), 0);
            chk("stall_key_req", int'(key_req), 1);
        end
        @(posedge clk); #1;
        key_valid = 1'b1;
        wait_idle(1'b0, "blk2_timeout");

        // Consumer backpressure for four cycles; in_valid held high meanwhile.
        out_ready = 1'b0;
        issue(1'b0, t0);
        push_blk(1'b0, 10, 1'b1, t0 + 12);
        for (int i = 0; i < 40 && out_valid != 1'b1; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_round_idx", int'(round_idx), 10);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("bp_exit_in_ready", int'(in_ready), 1);
        chk("bp_exit_out_valid", int'(out_valid), 0);
        chk("bp_exit_busy", int'(busy), 0);

        // Reset in the middle of round 6, then a clean block.
        issue(1'b0, t0);
        push_blk(1'b0, 6, 1'b0, 0);
        for (int i = 0; i < 40 && round_idx != 4'd6; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_reach_idx6", int'(round_idx), 6);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outs("midrst");
        rst = 1'b0;
        issue(1'b0, t0);
        push_blk(1'b0, 10, 1'b1, t0 + 12);
        wait_idle(1'b0, "blk5_timeout");

        // AES-256 round count.
        issue(1'b1, t0);
        push_blk(1'b1, 14, 1'b1, t0 + 16);
        wait_idle(1'b1, "blk14_timeout");

        repeat (3) @(posedge clk);
        chk("q_st10_drained", q_st10.size(), 0);
        chk("q_out10_drained", q_out10.size(), 0);
        chk("q_st14_drained", q_st14.size(), 0);
        chk("q_out14_drained", q_out14.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
